tl_master_arbiter: RTL and testbench
====================================

# tl_master_arbiter

Two-master TileLink-UH A/D channel arbiter that shares the single downstream bus port between the instruction cache (master 0) and the data cache (master 1). It grants one transaction at a time and holds the grant across all A beats (PutFull bursts, e.g. CBO.ZERO line writes). It then routes every D beat back to the owning master until the response is complete. Priority is round-robin, with the data cache preferred after reset. It sits between the cache controllers and the memory-side TileLink interconnect.

## Interface
- MAX_SIZE, 7: largest legal `a_size` (log2 bytes); one line = 128 B = 32 beats of 4 B.
- cpu_clock_i  in  1  sole clock; all state changes on its rising edge.
- cpu_reset_i  in  1  synchronous, active-high reset.
- m0_a_opcode/param/size/address/mask/data/corrupt/valid  in  3/3/4/32/4/32/1/1  icache A request.
- m0_a_ready  out  1  A accept to icache.
- m1_a_opcode/param/size/address/mask/data/corrupt/valid  in  3/3/4/32/4/32/1/1  dcache A request.
- m1_a_ready  out  1  A accept to dcache.
- mN_d_opcode/param/size/denied/data/corrupt/valid (N=0,1)  out  3/2/4/1/32/1/1  D response to master N.
- mN_d_ready (N=0,1)  in  1  D accept from master N.
- bus_a_opcode/param/size/address/mask/data/corrupt/valid  out  3/3/4/32/4/32/1/1  downstream A.
- bus_a_ready  in  1  downstream A accept.
- bus_d_opcode/param/size/denied/data/corrupt/valid  in  3/2/4/1/32/1/1  downstream D.
- bus_d_ready  out  1  D accept to downstream.
- grant_o  out  2  one-hot current owner, 00 when idle.
- arb_err_o  out  1  sticky protocol-error flag.

## Operation
- States:
  - IDLE: all mN_a_ready=0, bus_a_valid=0, bus_d_ready=1, grant_o=00.
  - ACTIVE: owner's bundle is connected to the bus.
- Arbitration (IDLE):
  - If any mN_a_valid, the winner is latched and the FSM moves to ACTIVE.
  - If both request, the master selected by the rr pointer wins.
  - Reset sets rr to prefer M1.
- Beat counts latched at grant, from the winner's opcode and size:
  - beats(s) = 1 if s<=2, else 1<<(s-2).
  - a_left = beats(size) for PutFull(0)/PutPartial(1); otherwise 1.
  - d_left = beats(size) for Get(4); otherwise 1.
  - Counters are 6 bits.
  - size>MAX_SIZE: clamp to 32 beats and set arb_err_o.
- ACTIVE, A channel:
  - bus_a_* = owner's a_* fields.
  - bus_a_valid = owner_a_valid & (a_left!=0).
  - owner_a_ready = bus_a_ready & (a_left!=0).
  - a_left decrements on each bus A handshake.
  - The non-owner's a_ready is 0.
- ACTIVE, D channel:
  - The owner's d_* fields are driven from bus_d_*, with owner_d_valid = bus_d_valid.
  - bus_d_ready = owner_d_ready.
  - The non-owner's d_valid is 0; its other d_* fields are don't-care, driven 0.
  - d_left decrements on each D handshake.
- Completion:
  - When a_left==0 and d_left==0 (after counting this cycle's handshakes), the FSM returns to IDLE next cycle.
  - rr is set to prefer the non-finishing master.
- A D beat may arrive before the final A beat (PutFull early ack); it is routed and counted normally.
- A D handshake while IDLE is dropped (bus_d_ready=1) and sets arb_err_o.
- arb_err_o clears only on reset.
- Reset mid-transaction:
  - State→IDLE, counters→0, rr→M1, arb_err_o→0.
  - Any in-flight beats are abandoned.

## Timing
- Reset values:
  - All mN_a_ready=0, mN_d_valid=0, bus_a_valid=0, grant_o=00, arb_err_o=0.
  - bus_d_ready=1.
  - All data/field outputs 0.
- Grant latency:
  - mN_a_valid rises in IDLE at cycle t.
  - grant_o is set and bus_a_valid is forwarded at t+1.
- A/D forwarding is combinational in ACTIVE: zero added latency per beat.
- Back-to-back:
  - Last D handshake at cycle t → IDLE at t+1.
  - Next grant is visible at t+2.
  - Minimum one idle cycle between transactions.
- Masters hold A fields stable while valid and unaccepted (TileLink rule).

## Test plan
- M1 Get size 2, addr 0x8000_0010, alone:
  - grant_o=10 one cycle after valid; one A beat forwarded.
  - Single D beat (data 0xDEADBEEF) appears on m1_d only; m0_d_valid stays 0; IDLE after.
- Both request in the same cycle after reset:
  - M1 granted first, then M0.
  - A third simultaneous pair grants M1 again (round-robin).
- M0 Get size 7, addr 0x0000_1000:
  - One A beat, then 32 D beats with bus_d_valid toggling.
  - Grant holds until the 32nd beat; a pending m1_a_valid sees m1_a_ready=0 throughout.
- M1 PutFull size 7 (CBO.ZERO, data 0):
  - 32 A beats with bus_a_ready asserted on alternate cycles; all 32 forwarded.
  - One AccessAck D beat ends the transaction.
- Backpressure: m1_d_ready=0 during a Get size 3:
  - bus_d_ready=0 and no beat counted.
  - Both beats complete after ready returns.
- Error and reset:
  - Unsolicited bus_d_valid in IDLE → bus_d_ready=1, arb_err_o=1 sticky.
  - Assert cpu_reset_i mid-burst → next cycle IDLE, grant_o=00, arb_err_o=0.

Source files
------------

// File: rtl/tl_master_arbiter_if.sv
// One TileLink-UH A/D channel pair.
// The "master" modport is the requester side and the "slave" modport is the responder side.
interface tl_master_arbiter_if;
    // A channel: request from the master side
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;

    // D channel: response from the slave side
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_address, a_mask, a_data, a_corrupt, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_denied, d_data, d_corrupt, d_valid,
        output d_ready
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_address, a_mask, a_data, a_corrupt, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_denied, d_data, d_corrupt, d_valid,
        input  d_ready
    );
endinterface

// File: rtl/tl_master_arbiter.sv
// Two-master TileLink-UH arbiter.
// m0 is the icache and m1 is the dcache; both share one downstream port, bus.
// One transaction is owned at a time. The owner keeps the grant until all of its
// A beats and D beats have handshaked. Priority is round-robin, and M1 is
// preferred after reset.
module tl_master_arbiter #(
    parameter int MAX_SIZE = 7
) (
    input  logic                  cpu_clock_i,
    input  logic                  cpu_reset_i,
    tl_master_arbiter_if.slave    m0,
    tl_master_arbiter_if.slave    m1,
    tl_master_arbiter_if.master   bus,
    output logic [1:0]            grant_o,
    output logic                  arb_err_o
);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [3:0] SIZE_LIMIT     = 4'(MAX_SIZE);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;     // 0 = m0, 1 = m1
    logic        rr_reg, rr_next;           // 1 = prefer m1 on a tie
    logic [5:0]  a_left_reg, a_left_next;
    logic [5:0]  d_left_reg, d_left_next;
    logic        err_reg, err_next;

    // Number of 4-byte beats for a transfer of 2**size bytes.
    // Oversized requests are clamped to one full line.
    function automatic logic [5:0] beats_for(input logic [3:0] size);
        logic [5:0] n;
        if (size <= 4'd2) begin
            n = 6'd1;
        end else if (size > SIZE_LIMIT) begin
            n = 6'd32;
        end else begin
            n = 6'd1 << (size - 4'd2);
        end
        return n;
    endfunction

    // Winner selection and the beat counts loaded at grant time
    logic        any_req;
    logic        win_m1;
    logic [2:0]  win_opcode;
    logic [3:0]  win_size;
    logic [5:0]  win_beats;

    assign any_req    = m0.a_valid | m1.a_valid;
    assign win_m1     = m1.a_valid & (~m0.a_valid | rr_reg);
    assign win_opcode = win_m1 ? m1.a_opcode : m0.a_opcode;
    assign win_size   = win_m1 ? m1.a_size   : m0.a_size;
    assign win_beats  = beats_for(win_size);

    // Owner-side A fields and D ready. These are combinational so that no
    // latency is added to any beat.
    logic        active;
    logic        own_a_valid;
    logic        own_d_ready;
    logic        a_open;
    logic        a_fire;
    logic        d_fire;

    assign active      = (state_reg == ACTIVE);
    assign own_a_valid = owner_reg ? m1.a_valid : m0.a_valid;
    assign own_d_ready = owner_reg ? m1.d_ready : m0.d_ready;
    assign a_open      = (a_left_reg != 6'd0);
    assign a_fire      = active & own_a_valid & a_open & bus.a_ready;
    assign d_fire      = active & bus.d_valid & own_d_ready;

    // Per-master routing enables: route[gi] is set while master gi owns the bus.
    logic [1:0] route;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            assign route[gi] = active & (owner_reg == 1'(gi));
        end
    endgenerate

    // State register: arbiter FSM, owner, round-robin pointer, beat counters, sticky error
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            rr_reg     <= 1'b1;
            a_left_reg <= 6'd0;
            d_left_reg <= 6'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_reg     <= rr_next;
            a_left_reg <= a_left_next;
            d_left_reg <= d_left_next;
            err_reg    <= err_next;
        end
    end

    // Next-state logic: grant in IDLE; in ACTIVE, count handshakes and release the bus when both counters are empty
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_next     = rr_reg;
        a_left_next = a_left_reg;
        d_left_next = d_left_reg;
        err_next    = err_reg;

        case (state_reg)
            IDLE: begin
                // bus_d_ready is high in IDLE, so any D beat here is accepted and dropped
                if (bus.d_valid) begin
                    err_next = 1'b1;
                end
                if (any_req) begin
                    state_next = ACTIVE;
                    owner_next = win_m1;
                    if (win_opcode == OP_PUT_FULL || win_opcode == OP_PUT_PARTIAL) begin
                        a_left_next = win_beats;
                    end else begin
                        a_left_next = 6'd1;
                    end
                    if (win_opcode == OP_GET) begin
                        d_left_next = win_beats;
                    end else begin
                        d_left_next = 6'd1;
                    end
                    if (win_size > SIZE_LIMIT) begin
                        err_next = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (a_fire) begin
                    a_left_next = a_left_reg - 6'd1;
                end
                // Extra D beats beyond the expected count saturate rather than wrap
                if (d_fire && d_left_reg != 6'd0) begin
                    d_left_next = d_left_reg - 6'd1;
                end
                if (a_left_next == 6'd0 && d_left_next == 6'd0) begin
                    state_next = IDLE;
                    rr_next    = ~owner_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output muxing: owner's A bundle to the bus, bus D bundle to the owner, zeros elsewhere
    always_comb begin
        bus.a_opcode  = 3'd0;
        bus.a_param   = 3'd0;
        bus.a_size    = 4'd0;
        bus.a_address = 32'd0;
        bus.a_mask    = 4'd0;
        bus.a_data    = 32'd0;
        bus.a_corrupt = 1'b0;
        bus.a_valid   = 1'b0;
        bus.d_ready   = 1'b1;

        m0.a_ready    = 1'b0;
        m1.a_ready    = 1'b0;

        m0.d_opcode   = 3'd0;
        m0.d_param    = 2'd0;
        m0.d_size     = 4'd0;
        m0.d_denied   = 1'b0;
        m0.d_data     = 32'd0;
        m0.d_corrupt  = 1'b0;
        m0.d_valid    = 1'b0;

        m1.d_opcode   = 3'd0;
        m1.d_param    = 2'd0;
        m1.d_size     = 4'd0;
        m1.d_denied   = 1'b0;
        m1.d_data     = 32'd0;
        m1.d_corrupt  = 1'b0;
        m1.d_valid    = 1'b0;

        if (route[0]) begin
            bus.a_opcode  = m0.a_opcode;
            bus.a_param   = m0.a_param;
            bus.a_size    = m0.a_size;
            bus.a_address = m0.a_address;
            bus.a_mask    = m0.a_mask;
            bus.a_data    = m0.a_data;
            bus.a_corrupt = m0.a_corrupt;
            bus.a_valid   = m0.a_valid & a_open;
            m0.a_ready    = bus.a_ready & a_open;

            m0.d_opcode   = bus.d_opcode;
            m0.d_param    = bus.d_param;
            m0.d_size     = bus.d_size;
            m0.d_denied   = bus.d_denied;
            m0.d_data     = bus.d_data;
            m0.d_corrupt  = bus.d_corrupt;
            m0.d_valid    = bus.d_valid;
            bus.d_ready   = m0.d_ready;
        end

        if (route[1]) begin
            bus.a_opcode  = m1.a_opcode;
            bus.a_param   = m1.a_param;
            bus.a_size    = m1.a_size;
            bus.a_address = m1.a_address;
            bus.a_mask    = m1.a_mask;
            bus.a_data    = m1.a_data;
            bus.a_corrupt = m1.a_corrupt;
            bus.a_valid   = m1.a_valid & a_open;
            m1.a_ready    = bus.a_ready & a_open;

            m1.d_opcode   = bus.d_opcode;
            m1.d_param    = bus.d_param;
            m1.d_size     = bus.d_size;
            m1.d_denied   = bus.d_denied;
            m1.d_data     = bus.d_data;
            m1.d_corrupt  = bus.d_corrupt;
            m1.d_valid    = bus.d_valid;
            bus.d_ready   = m1.d_ready;
        end
    end

    assign grant_o   = route;
    assign arb_err_o = err_reg;

endmodule

// File: tb/tb_tl_master_arbiter.sv
// Directed bench for tl_master_arbiter.
// The bench drives inputs 2 time units after the rising edge.
// It checks outputs 1 time unit later, which is well away from the clock edge.
module tb_tl_master_arbiter;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic [1:0] grant;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tl_master_arbiter_if m0_if ();
    tl_master_arbiter_if m1_if ();
    tl_master_arbiter_if bus_if ();

    tl_master_arbiter #(.MAX_SIZE(7)) dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (srst),
        .m0          (m0_if),
        .m1          (m1_if),
        .bus         (bus_if),
        .grant_o     (grant),
        .arb_err_o   (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input int m, input logic v, input logic [2:0] op,
                             input logic [3:0] sz, input logic [31:0] addr,
                             input logic [31:0] data);
        if (m == 0) begin
            m0_if.a_valid = v; m0_if.a_opcode = op; m0_if.a_size = sz;
            m0_if.a_address = addr; m0_if.a_data = data;
        end else begin
            m1_if.a_valid = v; m1_if.a_opcode = op; m1_if.a_size = sz;
            m1_if.a_address = addr; m1_if.a_data = data;
        end
    endtask

    // Runs a single-beat Get for master m, which must already hold the grant.
    // The A beat is accepted first, then one D beat answers it.
    task automatic one_beat_get(input int m, input string tag);
        logic [1:0] g;
        g = (m == 1) ? 2'b10 : 2'b01;
        check({tag, "_grant"}, 32'(grant), 32'(g));
        check({tag, "_bus_a_valid"}, 32'(bus_if.a_valid), 32'd1);
        bus_if.a_ready = 1'b1;
        settle();
        check({tag, "_own_a_ready"}, 32'((m == 1) ? m1_if.a_ready : m0_if.a_ready), 32'd1);
        check({tag, "_other_a_ready"}, 32'((m == 1) ? m0_if.a_ready : m1_if.a_ready), 32'd0);
        tick();
        if (m == 1) m1_if.a_valid = 1'b0; else m0_if.a_valid = 1'b0;
        bus_if.a_ready  = 1'b0;
        bus_if.d_valid  = 1'b1;
        bus_if.d_opcode = 3'd1;
        bus_if.d_data   = 32'hDEADBEEF;
        settle();
        check({tag, "_a_done"}, 32'(bus_if.a_valid), 32'd0);
        check({tag, "_own_d_valid"}, 32'((m == 1) ? m1_if.d_valid : m0_if.d_valid), 32'd1);
        check({tag, "_own_d_data"}, (m == 1) ? m1_if.d_data : m0_if.d_data, 32'hDEADBEEF);
        check({tag, "_other_d_valid"}, 32'((m == 1) ? m0_if.d_valid : m1_if.d_valid), 32'd0);
        tick();
        bus_if.d_valid = 1'b0;
        settle();
        check({tag, "_idle"}, 32'(grant), 32'd0);
        $display("txn %s: master %0d single-beat Get complete", tag, m);
    endtask

    initial begin
        int beats;

        m0_if.a_valid = 0; m0_if.a_opcode = 0; m0_if.a_param = 0; m0_if.a_size = 0;
        m0_if.a_address = 0; m0_if.a_mask = 4'hF; m0_if.a_data = 0; m0_if.a_corrupt = 0;
        m0_if.d_ready = 1;
        m1_if.a_valid = 0; m1_if.a_opcode = 0; m1_if.a_param = 0; m1_if.a_size = 0;
        m1_if.a_address = 0; m1_if.a_mask = 4'hF; m1_if.a_data = 0; m1_if.a_corrupt = 0;
        m1_if.d_ready = 1;
        bus_if.a_ready = 0;
        bus_if.d_opcode = 0; bus_if.d_param = 0; bus_if.d_size = 0; bus_if.d_denied = 0;
        bus_if.d_data = 0; bus_if.d_corrupt = 0; bus_if.d_valid = 0;

        // Reset state
        srst = 1'b1;
        tick(); tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_bus_a_valid", 32'(bus_if.a_valid), 32'd0);
        check("rst_bus_d_ready", 32'(bus_if.d_ready), 32'd1);
        check("rst_m0_a_ready", 32'(m0_if.a_ready), 32'd0);
        check("rst_m1_d_valid", 32'(m1_if.d_valid), 32'd0);
        check("rst_bus_a_addr", bus_if.a_address, 32'd0);
        $display("txn reset: outputs idle");
        srst = 1'b0;

        // M1 Get size 2 alone
        drive_req(1, 1'b1, 3'd4, 4'd2, 32'h8000_0010, 32'd0);
        settle();
        check("m1get_pre_grant", 32'(grant), 32'd0);
        check("m1get_pre_a_ready", 32'(m1_if.a_ready), 32'd0);
        tick();
        check("m1get_addr", bus_if.a_address, 32'h8000_0010);
        check("m1get_size", 32'(bus_if.a_size), 32'd2);
        one_beat_get(1, "m1_get");

        // Simultaneous requests after reset: M1, then M0, then M1 again
        srst = 1'b1;
        tick();
        srst = 1'b0;
        drive_req(0, 1'b1, 3'd4, 4'd2, 32'h0000_0100, 32'd0);
        drive_req(1, 1'b1, 3'd4, 4'd2, 32'h0000_0200, 32'd0);
        tick();
        check("pair1_addr", bus_if.a_address, 32'h0000_0200);
        one_beat_get(1, "pair1_m1");
        tick();
        check("pair1_m0_addr", bus_if.a_address, 32'h0000_0100);
        one_beat_get(0, "pair1_m0");
        drive_req(0, 1'b1, 3'd4, 4'd2, 32'h0000_0300, 32'd0);
        drive_req(1, 1'b1, 3'd4, 4'd2, 32'h0000_0400, 32'd0);
        tick();
        one_beat_get(1, "pair2_m1");
        m0_if.a_valid = 1'b0;
        tick();
        check("pair2_no_grant", 32'(grant), 32'd0);

        // M0 Get size 7 with M1 PutFull pending; rr now prefers M0
        drive_req(0, 1'b1, 3'd4, 4'd7, 32'h0000_1000, 32'd0);
        drive_req(1, 1'b1, 3'd0, 4'd7, 32'h0000_2000, 32'd0);
        tick();
        check("line_grant", 32'(grant), 32'd1);
        check("line_size", 32'(bus_if.a_size), 32'd7);
        bus_if.a_ready = 1'b1;
        settle();
        check("line_a_ready", 32'(m0_if.a_ready), 32'd1);
        tick();
        m0_if.a_valid  = 1'b0;
        bus_if.a_ready = 1'b0;
        settle();
        check("line_a_done", 32'(bus_if.a_valid), 32'd0);
        beats = 0;
        for (int c = 0; c < 200 && beats < 32; c++) begin
            bus_if.d_valid  = c[0];
            bus_if.d_opcode = 3'd1;
            bus_if.d_data   = 32'h1000 + 32'(beats);
            settle();
            check("line_m1_blocked", 32'(m1_if.a_ready), 32'd0);
            if (bus_if.d_valid) begin
                check("line_d_data", m0_if.d_data, 32'h1000 + 32'(beats));
                check("line_grant_hold", 32'(grant), 32'd1);
            end
            tick();
            if (bus_if.d_valid) beats++;
        end
        bus_if.d_valid = 1'b0;
        check("line_beats", 32'(beats), 32'd32);
        settle();
        check("line_idle", 32'(grant), 32'd0);
        $display("txn m0_get_line: %0d D beats", beats);

        // M1 PutFull size 7 with bus_a_ready on alternate cycles
        tick();
        check("put_grant", 32'(grant), 32'd2);
        beats = 0;
        for (int c = 0; c < 200 && beats < 32; c++) begin
            bus_if.a_ready = c[0];
            settle();
            check("put_a_valid", 32'(bus_if.a_valid), 32'd1);
            check("put_a_opcode", 32'(bus_if.a_opcode), 32'd0);
            check("put_a_data", bus_if.a_data, 32'd0);
            check("put_m1_a_ready", 32'(m1_if.a_ready), 32'(c[0]));
            tick();
            if (bus_if.a_ready) beats++;
        end
        bus_if.a_ready = 1'b1;
        settle();
        check("put_beats", 32'(beats), 32'd32);
        check("put_a_gated", 32'(bus_if.a_valid), 32'd0);
        check("put_a_ready_gated", 32'(m1_if.a_ready), 32'd0);
        m1_if.a_valid   = 1'b0;
        bus_if.a_ready  = 1'b0;
        bus_if.d_valid  = 1'b1;
        bus_if.d_opcode = 3'd0;
        bus_if.d_data   = 32'd0;
        settle();
        check("put_ack_valid", 32'(m1_if.d_valid), 32'd1);
        check("put_ack_opcode", 32'(m1_if.d_opcode), 32'd0);
        check("put_ack_grant", 32'(grant), 32'd2);
        tick();
        bus_if.d_valid = 1'b0;
        settle();
        check("put_idle", 32'(grant), 32'd0);
        $display("txn m1_putfull_line: %0d A beats", beats);

        // Backpressure on M1 D during a Get size 3
        drive_req(1, 1'b1, 3'd4, 4'd3, 32'h0000_3000, 32'd0);
        tick();
        check("bp_grant", 32'(grant), 32'd2);
        bus_if.a_ready = 1'b1;
        tick();
        m1_if.a_valid   = 1'b0;
        bus_if.a_ready  = 1'b0;
        m1_if.d_ready   = 1'b0;
        bus_if.d_valid  = 1'b1;
        bus_if.d_opcode = 3'd1;
        bus_if.d_data   = 32'h0000_00AA;
        settle();
        check("bp_bus_d_ready", 32'(bus_if.d_ready), 32'd0);
        check("bp_m1_d_valid", 32'(m1_if.d_valid), 32'd1);
        tick(); tick();
        check("bp_hold", 32'(grant), 32'd2);
        m1_if.d_ready = 1'b1;
        settle();
        check("bp_ready_back", 32'(bus_if.d_ready), 32'd1);
        tick();
        settle();
        check("bp_after_beat1", 32'(grant), 32'd2);
        tick();
        bus_if.d_valid = 1'b0;
        settle();
        check("bp_idle", 32'(grant), 32'd0);
        $display("txn m1_get_bp: 2 D beats after stall");

        // Unsolicited D beat in IDLE
        check("err_before", 32'(err), 32'd0);
        bus_if.d_valid = 1'b1;
        settle();
        check("err_d_ready", 32'(bus_if.d_ready), 32'd1);
        check("err_m0_d_valid", 32'(m0_if.d_valid), 32'd0);
        check("err_m1_d_valid", 32'(m1_if.d_valid), 32'd0);
        tick();
        bus_if.d_valid = 1'b0;
        settle();
        check("err_set", 32'(err), 32'd1);
        tick();
        check("err_sticky", 32'(err), 32'd1);
        $display("txn idle_d_beat: error flagged");

        // Reset in the middle of an M0 PutFull burst
        drive_req(0, 1'b1, 3'd0, 4'd7, 32'h0000_4000, 32'h1234_5678);
        tick();
        check("rstmid_grant", 32'(grant), 32'd1);
        bus_if.a_ready = 1'b1;
        tick(); tick(); tick();
        srst = 1'b1;
        tick();
        check("rstmid_grant_clr", 32'(grant), 32'd0);
        check("rstmid_err_clr", 32'(err), 32'd0);
        check("rstmid_bus_a_valid", 32'(bus_if.a_valid), 32'd0);
        check("rstmid_m0_a_ready", 32'(m0_if.a_ready), 32'd0);
        srst = 1'b0;
        m0_if.a_valid  = 1'b0;
        bus_if.a_ready = 1'b0;
        tick();
        check("rstmid_stay_idle", 32'(grant), 32'd0);
        $display("txn reset_mid_burst: abandoned");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
